l1c_inst_2way: RTL and testbench
================================

Name: l1c_inst_2way

Overview:
Parametrised 2-way set-associative, read-only L1 instruction cache between the CPU core fetch port and the CPU wrapper's instruction memory port. Replaces the direct-mapped instruction cache, and adds three things to it:
- configurable sets and line length;
- pseudo-LRU replacement;
- a whole-cache flush.

Tag, data and valid storage are internal register arrays, so no SRAM wrappers are used. Each line miss is refilled with a sequential word-by-word burst.

Parameters:
ADDR_W, 32, byte address width.
SETS, 64, number of sets; power of two, at least 2.
LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
clk  in  1  clock
rst  in  1  reset
core_req  in  1  fetch request, held until core_wait low
core_addr  in  ADDR_W  fetch byte address, word aligned
flush  in  1  invalidate-all request, single-cycle pulse
core_out  out  32  fetched instruction, registered
core_wait  out  1  high while fetch or flush incomplete
mem_rreq  out  1  refill beat request
mem_addr  out  ADDR_W  refill beat byte address
mem_rdata  in  32  refill beat data
mem_wait  in  1  low = beat accepted and mem_rdata valid this cycle

Behaviour:
- Clock and reset: reset rst, asynchronous, active-high; clock clk.
- Field widths:
  - OFF = log2(LINE_WORDS)+2.
  - IDX = log2(SETS).
  - TAG = ADDR_W-IDX-OFF.
  - Set index = addr[OFF+IDX-1:OFF]. Word select = addr[OFF-1:2].
- Reset values: core_out=0, mem_rreq=0, all valid bits=0, all lru bits=0, beat counter=0, flush_pend=0, state=IDLE. core_wait is combinational and follows the state rules below.
- Reset mid-refill: abort the burst. mem_rreq drops asynchronously, the partial line is discarded and the state is IDLE.
- States: IDLE, LOOKUP, REFILL, DONE, FLUSH.
- IDLE:
  - If flush_pend or flush: go to FLUSH, core_wait=1.
  - Else if core_req: latch core_addr, go to LOOKUP, core_wait=1.
  - Else: core_wait=0.
- LOOKUP:
  - Compare the latched tag against both ways, with the valid bit qualified.
  - Hit: core_out <= selected word; lru[set] <= ~hit_way; go to DONE.
  - Miss: beat counter=0; go to REFILL.
  - A double hit cannot occur. If it does, way0 wins.
- REFILL:
  - mem_rreq=1.
  - mem_addr = {line base, beat, 2'b00}; beats run sequentially from word 0.
  - Each cycle with mem_wait=0: store mem_rdata into the line buffer slot [beat], then beat++.
  - After beat LINE_WORDS-1 is accepted:
    - mem_rreq drops in the next cycle.
    - Write the line buffer, tag and valid=1 into the victim way.
    - lru[set] <= ~victim.
    - core_out <= requested word; if the requested word is the last beat, take it directly from mem_rdata.
    - Go to DONE.
  - Victim selection: the first invalid way, way0 first. If both ways are valid, the way given by lru[set].
- DONE: core_wait=0 for exactly one cycle, with core_out valid; return to IDLE.
- Latency from the core_req cycle: a hit returns data in cycle 3. A miss takes 3 + LINE_WORDS + total mem_wait stall cycles.
- FLUSH:
  - Clear every valid bit and every lru bit in one cycle.
  - Clear flush_pend; go to IDLE.
  - core_wait=1 in FLUSH even when core_req=0.
- Flush while busy (LOOKUP/REFILL/DONE): set flush_pend. The current access completes normally and the flush is serviced on the next IDLE, with priority over core_req.
- A core_addr change while core_wait=1 is ignored, because the address is latched.

Optional Feature:
Macro: L1CI_PERF_EN.
- Defined, the block adds three 32-bit outputs, all reset to 0, wrapping modulo 2^32, and not cleared by flush:
  - perf_hits: increments in LOOKUP on a hit.
  - perf_miss: increments when a refill completes.
  - perf_reqs: increments when a request is accepted in IDLE.
- Undefined: these ports and registers are absent, and function is otherwise identical.

Test Plan:
1. Cold miss, then hit.
   - Stimulus: reset; fetch 0x0000_0104; mem_rdata = address of each beat; mem_wait=0.
   - Response: 4 beats at 0x100, 0x104, 0x108, 0x10C; core_out=0x104 in DONE at cycle 7.
   - Then re-fetch 0x108: no mem_rreq; core_out=0x108 in DONE at cycle 3.
2. Way fill and LRU eviction.
   - Stimulus: fetch 0x0000, 0x0400, 0x0000, then 0x0800 (all set 0).
   - Response: 0x0800 evicts way holding 0x0400. Re-fetch 0x0000 hits; re-fetch 0x0400 misses.
3. Refill stalls.
   - Stimulus: mem_wait high for 2 cycles before each beat.
   - Response: mem_addr holds during each stall; miss latency = 3+4+8 = 15 cycles; data correct.
4. Flush.
   - Stimulus: pulse flush while in REFILL.
   - Response: the access completes with correct data; FLUSH follows; a subsequent fetch of the same address misses.
5. Reset mid-refill.
   - Stimulus: assert rst after beat 1.
   - Response: mem_rreq=0 and core_out=0 immediately; a later fetch of the same line misses and refills all 4 beats.
6. Parameter sweep with L1CI_PERF_EN defined.
   - Stimulus: SETS=16, LINE_WORDS=8; a loop of 100 fetches over a 256-byte region.
   - Response: perf_miss=8, perf_hits=92, perf_reqs=100.

Source files
------------

// File: rtl/l1c_inst_2way.sv
// 2-way set-associative read-only L1 instruction cache with pseudo-LRU, burst refill and whole-cache flush.
// Latency: hit data in cycle 3 after core_req; miss in 3 + LINE_WORDS + mem_wait stall cycles.
// Backpressure: core_wait holds the core while busy; refill beats advance only on cycles with mem_wait low.
//
// Ports: clk/rst (async, active-high); core_req/core_addr/core_out/core_wait form the fetch port;
// flush is a one-cycle invalidate-all pulse; mem_rreq/mem_addr/mem_rdata/mem_wait form the refill port.
// Optional macro L1CI_PERF_EN adds perf_hits/perf_miss/perf_reqs counters (wrap at 2^32, kept across flush).
module l1c_inst_2way #(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              flush,
    output logic [31:0]       core_out,
    output logic              core_wait,
    output logic              mem_rreq,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_wait
`ifdef L1CI_PERF_EN
    ,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_miss,
    output logic [31:0]       perf_reqs
`endif
);

    localparam int WSEL = $clog2(LINE_WORDS);
    localparam int OFF  = WSEL + 2;
    localparam int IDX  = $clog2(SETS);
    localparam int TAG  = ADDR_W - IDX - OFF;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, DONE, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [TAG-1:0]    tag_q;
    logic [IDX-1:0]    idx_q;
    logic [WSEL-1:0]   wsel_q;
    logic [WSEL-1:0]   beat_q;
    logic              flush_pend;
    logic [SETS-1:0]   valid_q [2];
    logic [SETS-1:0]   lru_q;          // per set: way to evict next

    logic [TAG-1:0]    tag_mem  [2][SETS];
    logic [31:0]       data_mem [2][SETS][LINE_WORDS];
    logic [31:0]       line_buf [LINE_WORDS];
    logic [31:0]       fill_line [LINE_WORDS];

    logic              hit0, hit1, hit, hit_way, victim;
    logic              accept, last_beat, fill_done;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^core_addr[1:0];

    assign hit0    = valid_q[0][idx_q] && (tag_mem[0][idx_q] == tag_q);
    assign hit1    = valid_q[1][idx_q] && (tag_mem[1][idx_q] == tag_q);
    assign hit     = hit0 || hit1;
    assign hit_way = !hit0;            // way0 wins a (theoretically impossible) double hit

    always_comb begin
        if (!valid_q[0][idx_q])
            victim = 1'b0;
        else if (!valid_q[1][idx_q])
            victim = 1'b1;
        else
            victim = lru_q[idx_q];
    end

    assign mem_rreq  = (state_q == REFILL);
    assign mem_addr  = {tag_q, idx_q, beat_q, 2'b00};
    assign accept    = mem_rreq && !mem_wait;
    assign last_beat = (beat_q == WSEL'(LINE_WORDS - 1));
    assign fill_done = accept && last_beat;

    // The last beat bypasses the buffer so the line can be written the cycle it arrives.
    always_comb begin
        for (int i = 0; i < LINE_WORDS; i++)
            fill_line[i] = line_buf[i];
        fill_line[LINE_WORDS-1] = mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        core_wait = 1'b1;
        case (state_q)
            IDLE: begin
                if (flush_pend || flush)
                    state_d = FLUSH;
                else if (core_req)
                    state_d = LOOKUP;
                else
                    core_wait = 1'b0;
            end
            LOOKUP:  state_d = hit ? DONE : REFILL;
            REFILL:  if (fill_done) state_d = DONE;
            DONE: begin
                core_wait = 1'b0;
                state_d   = IDLE;
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_out   <= '0;
            beat_q     <= '0;
            flush_pend <= 1'b0;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
            tag_q      <= '0;
            idx_q      <= '0;
            wsel_q     <= '0;
`ifdef L1CI_PERF_EN
            perf_hits  <= '0;
            perf_miss  <= '0;
            perf_reqs  <= '0;
`endif
        end else begin
            // A flush arriving mid-access is deferred until the access retires.
            if (flush && (state_q inside {LOOKUP, REFILL, DONE}))
                flush_pend <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (!(flush_pend || flush) && core_req) begin
                        tag_q  <= core_addr[ADDR_W-1:OFF+IDX];
                        idx_q  <= core_addr[OFF+IDX-1:OFF];
                        wsel_q <= core_addr[OFF-1:2];
`ifdef L1CI_PERF_EN
                        perf_reqs <= perf_reqs + 32'd1;
`endif
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        core_out     <= data_mem[hit_way][idx_q][wsel_q];
                        lru_q[idx_q] <= ~hit_way;
`ifdef L1CI_PERF_EN
                        perf_hits    <= perf_hits + 32'd1;
`endif
                    end else begin
                        beat_q <= '0;
                    end
                end
                REFILL: begin
                    if (accept)
                        beat_q <= beat_q + WSEL'(1);
                    if (fill_done) begin
                        valid_q[victim][idx_q] <= 1'b1;
                        lru_q[idx_q]           <= ~victim;
                        core_out               <= fill_line[wsel_q];
`ifdef L1CI_PERF_EN
                        perf_miss              <= perf_miss + 32'd1;
`endif
                    end
                end
                FLUSH: begin
                    valid_q[0] <= '0;
                    valid_q[1] <= '0;
                    lru_q      <= '0;
                    flush_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Storage arrays carry no reset; valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (accept)
            line_buf[beat_q] <= mem_rdata;
        if (fill_done) begin
            tag_mem[victim][idx_q] <= tag_q;
            for (int i = 0; i < LINE_WORDS; i++)
                data_mem[victim][idx_q][i] <= fill_line[i];
        end
    end

endmodule

// File: tb/tb_l1c_inst_2way.sv
// Randomized self-checking bench for l1c_inst_2way against a recency-list cache model.
// Latency: checks hit/miss cycle counts from the core_req cycle.
// Backpressure: memory responder inserts a configurable number of mem_wait stalls per beat.
module tb_l1c_inst_2way;

    localparam int AW     = 32;
    localparam int SETS_T = 64;
    localparam int LW_T   = 4;
    localparam int OFF_T  = 4;   // log2(LW_T) + 2

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req;
    logic [31:0] core_addr;
    logic        flush;
    logic [31:0] core_out;
    logic        core_wait;
    logic        mem_rreq;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_wait;
`ifdef L1CI_PERF_EN
    logic [31:0] perf_hits, perf_miss, perf_reqs;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    int          stall_n = 0;
    logic [31:0] beat_q [$];
    logic [31:0] mdl [SETS_T][$];   // per set: resident line numbers, most recent first
    int          m_hits = 0, m_miss = 0, m_reqs = 0;

    always #5 clk = ~clk;

    // Memory returns the beat address as data; garbage while stalled.
    assign mem_rdata = mem_wait ? 32'hDEAD_BEEF : mem_addr;

    l1c_inst_2way #(.ADDR_W(AW), .SETS(SETS_T), .LINE_WORDS(LW_T)) dut (
        .clk       (clk),
        .rst       (rst),
        .core_req  (core_req),
        .core_addr (core_addr),
        .flush     (flush),
        .core_out  (core_out),
        .core_wait (core_wait),
        .mem_rreq  (mem_rreq),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wait  (mem_wait)
`ifdef L1CI_PERF_EN
        ,
        .perf_hits (perf_hits),
        .perf_miss (perf_miss),
        .perf_reqs (perf_reqs)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic bit model_access(input logic [31:0] a);
        logic [31:0] ln;
        int          s;
        bit          h;
        ln = a >> OFF_T;
        s  = int'(ln % SETS_T);
        h  = 1'b0;
        for (int i = 0; i < mdl[s].size(); i++) begin
            if (mdl[s][i] == ln) begin
                h = 1'b1;
                mdl[s].delete(i);
                break;
            end
        end
        mdl[s].push_front(ln);
        if (mdl[s].size() > 2)
            void'(mdl[s].pop_back());
        return h;
    endfunction

    function automatic void model_flush();
        for (int s = 0; s < SETS_T; s++)
            mdl[s].delete();
    endfunction

    // Memory responder: stall_n cycles of mem_wait before each accepted beat.
    initial begin : responder
        int          cnt;
        bit          stalled;
        logic [31:0] hold;
        mem_wait = 1'b1;
        cnt      = 0;
        stalled  = 1'b0;
        hold     = '0;
        forever begin
            @(negedge clk);
            if (mem_rreq) begin
                if (cnt < stall_n) begin
                    mem_wait = 1'b1;
                    cnt++;
                    if (!stalled) hold = mem_addr;
                    stalled = 1'b1;
                end else begin
                    if (stalled) check("stall_addr_hold", mem_addr, hold);
                    mem_wait = 1'b0;
                    cnt      = 0;
                    stalled  = 1'b0;
                    beat_q.push_back(mem_addr);
                end
            end else begin
                mem_wait = 1'b1;
                cnt      = 0;
                stalled  = 1'b0;
            end
        end
    end

    // flush_sel: 0 = no flush, >0 = pulse flush in that cycle, <0 = random busy cycle.
    task automatic do_fetch(input logic [31:0] a, input int flush_sel);
        bit          h, done, pend;
        int          exp_lat, cyc, fcyc;
        logic [31:0] base;
        h       = model_access(a);
        exp_lat = h ? 3 : 3 + LW_T * (1 + stall_n);
        fcyc    = (flush_sel < 0) ? int'($urandom_range(2, exp_lat - 1)) : flush_sel;
        pend    = (fcyc >= 2) && (fcyc < exp_lat);
        base    = a & ~(32'(LW_T) * 4 - 1);
        beat_q.delete();
        @(negedge clk);
        core_req  = 1'b1;
        core_addr = a;
        flush     = 1'b0;
        #1;
        check("wait_on_req", {31'd0, core_wait}, 1);
        cyc  = 1;
        done = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            flush     = (cyc == fcyc);
            core_addr = $urandom();
            #1;
            if (!core_wait) done = 1'b1;
        end
        flush = 1'b0;
        check("fetch_done", {31'd0, done}, 1);
        check("latency", cyc, exp_lat);
        check("core_out", core_out, a);
        check("beat_count", beat_q.size(), h ? 0 : LW_T);
        foreach (beat_q[i])
            check("beat_addr", beat_q[i], base + 32'(4 * i));
        core_req = 1'b0;
        m_reqs++;
        if (h) m_hits++; else m_miss++;
        if (pend) begin
            @(negedge clk); #1 check("pend_idle_wait", {31'd0, core_wait}, 1);
            @(negedge clk); #1 check("pend_flush_wait", {31'd0, core_wait}, 1);
            @(negedge clk); #1 check("pend_flush_exit", {31'd0, core_wait}, 0);
            model_flush();
        end
    endtask

    task automatic flush_idle();
        @(negedge clk);
        flush = 1'b1;
        #1 check("fl_idle_wait", {31'd0, core_wait}, 1);
        @(negedge clk);
        flush = 1'b0;
        #1 check("fl_state_wait", {31'd0, core_wait}, 1);
        @(negedge clk);
        #1 check("fl_exit_wait", {31'd0, core_wait}, 0);
        model_flush();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int          w;
        logic [31:0] a;
        rst       = 1'b1;
        core_req  = 1'b0;
        core_addr = '0;
        flush     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_core_out", core_out, 0);
        check("rst_mem_rreq", {31'd0, mem_rreq}, 0);
        check("rst_core_wait", {31'd0, core_wait}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Cold miss then hit in the same line.
        do_fetch(32'h0000_0104, 0);
        do_fetch(32'h0000_0108, 0);

        // Fill both ways of set 0, then evict the least recent.
        do_fetch(32'h0000_0000, 0);
        do_fetch(32'h0000_0400, 0);
        do_fetch(32'h0000_0000, 0);
        do_fetch(32'h0000_0800, 0);
        do_fetch(32'h0000_0000, 0);
        do_fetch(32'h0000_0400, 0);

        // Refill with two stall cycles per beat.
        stall_n = 2;
        do_fetch(32'h0000_2004, 0);
        stall_n = 0;

        // Flush during refill, then the same line must miss.
        do_fetch(32'h0000_3008, 4);
        do_fetch(32'h0000_3008, 0);
        do_fetch(32'h0000_0104, 0);

        // Reset after beat 1 of a refill.
        beat_q.delete();
        @(negedge clk);
        core_req  = 1'b1;
        core_addr = 32'h0000_5010;
        w = 0;
        while (beat_q.size() < 2 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("rst_mid_beats_seen", {31'd0, beat_q.size() >= 2}, 1);
        @(posedge clk);
        #1 check("rreq_before_rst", {31'd0, mem_rreq}, 1);
        #1;
        rst      = 1'b1;
        core_req = 1'b0;
        #1;
        check("rst_mid_rreq", {31'd0, mem_rreq}, 0);
        check("rst_mid_core_out", core_out, 0);
        check("rst_mid_wait", {31'd0, core_wait}, 0);
        @(negedge clk);
        rst = 1'b0;
        model_flush();
        m_hits = 0;
        m_miss = 0;
        m_reqs = 0;
        do_fetch(32'h0000_5010, 0);

        // Random traffic: 3 tags competing for 4 sets, random stalls and flushes.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                flush_idle();
            end else begin
                stall_n = $urandom_range(0, 2);
                a = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4)
                  | (32'($urandom_range(0, 3)) << 2);
                do_fetch(a, ($urandom_range(0, 5) == 0) ? -1 : 0);
            end
        end

`ifdef L1CI_PERF_EN
        check("perf_hits", perf_hits, m_hits);
        check("perf_miss", perf_miss, m_miss);
        check("perf_reqs", perf_reqs, m_reqs);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
